multicycle_control_unit: RTL and testbench



---
 rtl/cu_pkg.sv | 50 +++++
 rtl/cu_decode.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 150 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// PC/write-source selects and the opcode class flags.
package cu_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [1:0] PC_SRC_NEXT   = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd2;

    localparam logic [1:0] WSRC_ALU  = 2'd0;
    localparam logic [1:0] WSRC_MEM  = 2'd1;
    localparam logic [1:0] WSRC_LINK = 2'd2;

    typedef struct packed {
        logic is_alu;
        logic is_jump;
        logic is_link;
        logic is_branch;
        logic is_load;
        logic is_store;
        logic writes_r0;
    } op_class_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier: turns the 4-bit opcode into the class flags the FSM steers on.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        unique case (opcode)
            OP_MOVE, OP_NOT, OP_SLL, OP_SRL, OP_ADDI, OP_LI: begin
                op_class.is_alu = 1'b1;
            end
            OP_ADD, OP_AND, OP_NOR, OP_SLT: begin
                op_class.is_alu    = 1'b1;
                op_class.writes_r0 = 1'b1;
            end
            OP_J: begin
                op_class.is_jump = 1'b1;
            end
            OP_JAL: begin
                op_class.is_jump = 1'b1;
                op_class.is_link = 1'b1;
            end
            OP_LW: begin
                op_class.is_load = 1'b1;
            end
            OP_SW: begin
                op_class.is_store = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                op_class.is_branch = 1'b1;
                op_class.writes_r0 = 1'b1;
            end
            default: op_class = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: latches the instruction, then sequences
// FETCH/DECODE/EXEC/MEM/WB, holding memory strobes until mem_ack.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [4+2*REG_ADDR_W-1:0]      instr,
    input  logic                           instr_valid,
    input  logic                           alu_zero,
    input  logic                           mem_ack,
    output logic                           ir_load,
    output logic                           pc_en,
    output logic [1:0]                     pc_src,
    output logic [3:0]                     alu_op,
    output logic                           mem_r_en,
    output logic                           mem_w_en,
    output logic                           reg_w_en,
    output logic [1:0]                     sel_w_source,
    output logic [REG_ADDR_W-1:0]          reg_addr_0,
    output logic [REG_ADDR_W-1:0]          reg_addr_1,
    output logic [REG_ADDR_W-1:0]          reg_addr_w,
    output logic                           busy
);

    localparam int unsigned INSTR_W = OPCODE_W + 2 * REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] LINK_REG = '1;

    state_t              state, state_next;
    logic [INSTR_W-1:0]  ir;
    logic [3:0]          opcode;
    logic [REG_ADDR_W-1:0] rs1, rs2;
    op_class_t           op_class;
    logic                branch_taken;

    assign opcode = ir[INSTR_W-1 -: OPCODE_W];
    assign rs1    = ir[REG_ADDR_W-1:0];
    assign rs2    = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];

    cu_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // beq takes on a zero result, bne on a non-zero one
    assign branch_taken = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;

    // Register-file addressing is a pure function of the held instruction
    assign reg_addr_0 = rs1;
    assign reg_addr_1 = rs2;
    always_comb begin
        reg_addr_w = rs2;
        if (op_class.writes_r0) begin
            reg_addr_w = '0;
        end else if (op_class.is_link) begin
            reg_addr_w = LINK_REG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (instr_valid) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (op_class.is_jump) begin
                    state_next = op_class.is_link ? WB : FETCH;
                end else if (op_class.is_branch) begin
                    state_next = FETCH;
                end else if (op_class.is_load || op_class.is_store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (mem_ack) state_next = op_class.is_load ? WB : FETCH;
            end
            WB:      state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_SRC_NEXT;
        alu_op       = 4'h0;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        reg_w_en     = 1'b0;
        sel_w_source = WSRC_ALU;
        busy         = (state != FETCH);
        unique case (state)
            FETCH: begin
                ir_load = instr_valid;
            end
            DECODE: begin
            end
            EXEC: begin
                alu_op = opcode;
                if (op_class.is_jump) begin
                    pc_en  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                end else if (op_class.is_branch) begin
                    pc_en  = 1'b1;
                    pc_src = branch_taken ? PC_SRC_BRANCH : PC_SRC_NEXT;
                end
            end
            MEM: begin
                mem_r_en = op_class.is_load;
                mem_w_en = op_class.is_store;
                // a store retires here, so it owns the PC advance
                pc_en    = op_class.is_store & mem_ack;
            end
            WB: begin
                reg_w_en = 1'b1;
                if (op_class.is_load) begin
                    sel_w_source = WSRC_MEM;
                end else if (op_class.is_link) begin
                    sel_w_source = WSRC_LINK;
                end
                pc_en = ~op_class.is_link;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit (REG_ADDR_W=2 and 3 builds).
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0] instr;
    logic       instr_valid, alu_zero, mem_ack;
    logic       ir_load, pc_en, mem_r_en, mem_w_en, reg_w_en, busy;
    logic [1:0] pc_src, sel_w_source, reg_addr_0, reg_addr_1, reg_addr_w;
    logic [3:0] alu_op;

    logic [9:0] instr3;
    logic       instr_valid3, alu_zero3, mem_ack3;
    logic       ir_load3, pc_en3, mem_r_en3, mem_w_en3, reg_w_en3, busy3;
    logic [1:0] pc_src3, sel_w_source3;
    logic [2:0] reg_addr_03, reg_addr_13, reg_addr_w3;
    logic [3:0] alu_op3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.REG_ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .ir_load(ir_load), .pc_en(pc_en),
        .pc_src(pc_src), .alu_op(alu_op), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .reg_w_en(reg_w_en), .sel_w_source(sel_w_source), .reg_addr_0(reg_addr_0),
        .reg_addr_1(reg_addr_1), .reg_addr_w(reg_addr_w), .busy(busy)
    );

    multicycle_control_unit #(.REG_ADDR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr(instr3), .instr_valid(instr_valid3),
        .alu_zero(alu_zero3), .mem_ack(mem_ack3), .ir_load(ir_load3), .pc_en(pc_en3),
        .pc_src(pc_src3), .alu_op(alu_op3), .mem_r_en(mem_r_en3), .mem_w_en(mem_w_en3),
        .reg_w_en(reg_w_en3), .sel_w_source(sel_w_source3), .reg_addr_0(reg_addr_03),
        .reg_addr_1(reg_addr_13), .reg_addr_w(reg_addr_w3), .busy(busy3)
    );

    // One row = one clock cycle: inputs driven, outputs expected in that cycle
    typedef struct {
        string      name;
        logic       rst_n;
        logic [7:0] instr;
        logic       iv, az, ack;
        logic       ir_load, pc_en;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic       mr, mw, rw;
        logic [1:0] wsrc, a0, a1, aw;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic r, logic [7:0] ins, logic iv, logic az,
                                logic ack, logic ld, logic pe, logic [1:0] ps, logic [3:0] op,
                                logic mr, logic mw, logic rw, logic [1:0] ws, logic [1:0] a0,
                                logic [1:0] a1, logic [1:0] aw, logic bz);
        vec_t v;
        v.name = name; v.rst_n = r; v.instr = ins; v.iv = iv; v.az = az; v.ack = ack;
        v.ir_load = ld; v.pc_en = pe; v.pc_src = ps; v.alu_op = op; v.mr = mr; v.mw = mw;
        v.rw = rw; v.wsrc = ws; v.a0 = a0; v.a1 = a1; v.aw = aw; v.busy = bz;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr = '0; instr_valid = 0; alu_zero = 0; mem_ack = 0;
        instr3 = '0; instr_valid3 = 0; alu_zero3 = 0; mem_ack3 = 0;

        //   name          rst ins  iv az ack  ld pe ps op  mr mw rw ws a0 a1 aw busy
        add("reset",       0, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("add_fetch",   1, 8'h1D,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("add_decode",  1, 8'hFF,1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        add("add_exec",    1, 8'h00,0, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 1);
        add("add_wb",      1, 8'h00,0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 1);
        add("idle_ack",    1, 8'h00,0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        add("lw_fetch",    1, 8'hAD,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        add("lw_decode",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1);
        add("lw_exec",     1, 8'h00,0, 0, 0,   0, 0, 0, 10,0, 0, 0, 0, 1, 3, 3, 1);
        add("lw_mem_w1",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 1);
        add("lw_mem_w2",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 1);
        add("lw_mem_w3",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 1);
        add("lw_mem_ack",  1, 8'h00,0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 1);
        add("lw_wb",       1, 8'h00,0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 1, 3, 3, 1);
        add("beq1_fetch",  1, 8'hC6,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        add("beq1_decode", 1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        add("beq_taken",   1, 8'h00,0, 1, 0,   0, 1, 2, 12,0, 0, 0, 0, 2, 1, 0, 1);
        add("beq2_fetch",  1, 8'hC6,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        add("beq2_decode", 1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        add("beq_nottaken",1, 8'h00,0, 0, 0,   0, 1, 0, 12,0, 0, 0, 0, 2, 1, 0, 1);
        add("bne1_fetch",  1, 8'hD6,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        add("bne1_decode", 1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        add("bne_taken",   1, 8'h00,0, 0, 0,   0, 1, 2, 13,0, 0, 0, 0, 2, 1, 0, 1);
        add("bne2_fetch",  1, 8'hD6,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        add("bne2_decode", 1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        add("bne_nottaken",1, 8'h00,0, 1, 0,   0, 1, 0, 13,0, 0, 0, 0, 2, 1, 0, 1);
        add("jal_fetch",   1, 8'h90,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        add("jal_decode",  1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        add("jal_exec",    1, 8'h00,0, 0, 0,   0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 3, 1);
        add("jal_wb",      1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 1);
        add("j_fetch",     1, 8'h86,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        add("j_decode",    1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1);
        add("j_exec",      1, 8'h00,0, 0, 0,   0, 1, 1, 8, 0, 0, 0, 0, 2, 1, 1, 1);
        add("sw_fetch",    1, 8'hB6,1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        add("sw_decode",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1);
        add("sw_exec",     1, 8'h00,0, 0, 0,   0, 0, 0, 11,0, 0, 0, 0, 2, 1, 1, 1);
        add("sw_mem_w1",   1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 1, 1);
        add("sw_mem_ack",  1, 8'h00,0, 0, 1,   0, 1, 0, 0, 0, 1, 0, 0, 2, 1, 1, 1);
        add("sw_done",     1, 8'h00,0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; instr = vecs[i].instr; instr_valid = vecs[i].iv;
            alu_zero = vecs[i].az; mem_ack = vecs[i].ack;
            #1;
            check(vecs[i].name,
                  64'({ir_load, pc_en, pc_src, alu_op, mem_r_en, mem_w_en, reg_w_en,
                       sel_w_source, reg_addr_0, reg_addr_1, reg_addr_w, busy}),
                  64'({vecs[i].ir_load, vecs[i].pc_en, vecs[i].pc_src, vecs[i].alu_op,
                       vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].wsrc, vecs[i].a0,
                       vecs[i].a1, vecs[i].aw, vecs[i].busy}));
        end

        // Asynchronous reset while a lw is parked in MEM waiting for mem_ack
        @(negedge clk); instr = 8'hAD; instr_valid = 1'b1; mem_ack = 1'b0;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_pre_mem_r_en", 64'(mem_r_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_mem_r_en", 64'(mem_r_en), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_ir", 64'({reg_addr_0, reg_addr_1, reg_addr_w}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("rst_no_wb", 64'({reg_w_en, busy, pc_en}), 64'd0);
        end

        // REG_ADDR_W=3 store with mem_ack on the first MEM cycle
        @(negedge clk); instr3 = 10'b1011_101_010; instr_valid3 = 1'b1; #1;
        check("w3_fetch_ir_load", 64'(ir_load3), 64'd1);
        @(negedge clk); instr_valid3 = 1'b0; #1;
        check("w3_decode_addr", 64'({reg_addr_03, reg_addr_13, reg_addr_w3}),
              64'({3'b010, 3'b101, 3'b101}));
        @(negedge clk); #1;
        check("w3_exec_alu_op", 64'({alu_op3, mem_w_en3}), 64'({4'hB, 1'b0}));
        @(negedge clk); mem_ack3 = 1'b1; #1;
        check("w3_mem_strobe", 64'({mem_w_en3, pc_en3, pc_src3, reg_w_en3, busy3}),
              64'({1'b1, 1'b1, 2'd0, 1'b0, 1'b1}));
        @(negedge clk); mem_ack3 = 1'b0; #1;
        check("w3_after_mem", 64'({mem_w_en3, pc_en3, reg_w_en3, busy3}), 64'd0);
        @(negedge clk); #1;
        check("w3_idle", 64'({mem_w_en3, reg_w_en3, busy3}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
